// File: rtl/autosym_pkg.sv
// Shared types and helpers for the autosymmetry input transform stage.
// Latency: n/a (package of types and combinational functions).
// Backpressure: n/a.
package autosym_pkg;

    localparam int N_IN_DEF  = 6;
    localparam int N_OUT_DEF = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef logic [N_IN_DEF-1:0]  vec_t;
    typedef logic [N_OUT_DEF-1:0] yvec_t;
    typedef vec_t [N_OUT_DEF-1:0] mat_t;

    // GF(2) matrix-vector product: each output bit is the parity of x masked by its row.
    function automatic yvec_t xform(input vec_t x, input mat_t m);
        yvec_t y;
        for (int k = 0; k < N_OUT_DEF; k++) begin
            y[k] = ^(x & m[k]);
        end
        return y;
    endfunction

    // Identity row k; rows beyond the input width have no source bit and are zero.
    function automatic vec_t identity_row(input int unsigned k);
        return (k < N_IN_DEF) ? (vec_t'(1) << k) : '0;
    endfunction

endpackage

// File: rtl/autosym_fifo.sv
// Synchronous first-word-fall-through FIFO, DEPTH entries of W bits.
// Latency: a word pushed at edge t is on head_dat_o from cycle t+1 when the FIFO was empty.
// Backpressure: pushes while full are ignored; head is held until popped.
// Ports: clk/rst_n; push_vld_i/push_dat_i write side; pop_i read side;
//        full_o/empty_o status; head_dat_o current head word (zero when empty).
module autosym_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_dat_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic         do_push;
    logic         do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o    = (wr_q == rd_q);
    assign full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push    = push_vld_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign head_dat_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + {{AW{1'b0}}, 1'b1};
        if (do_pop)  rd_d = rd_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: contents are only observed between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/autosym_xform_stage.sv
// Input-side GF(2) transform stage: external vectors or an exhaustive sweep, x -> y = M*x, queued as {x,y}.
// Latency: pushed pair visible on out_* the cycle after the push edge when the queue was empty.
// Backpressure: in_ready/sweep stall on queue full only; out_* held while out_valid && !out_ready.
// Ports: in_valid/in_ready/in_x external vectors; cfg_we/cfg_row/cfg_data/cfg_err matrix programming;
//        sweep_start/sweep_busy/sweep_done sweep control; out_valid/out_ready/out_x/out_y result queue head.
module autosym_xform_stage
    import autosym_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_OUT = N_OUT_DEF,
    parameter int DEPTH = 4,
    localparam int RW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_x,
    input  logic             cfg_we,
    input  logic [RW-1:0]    cfg_row,
    input  logic [N_IN-1:0]  cfg_data,
    output logic             cfg_err,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_IN-1:0]  out_x,
    output logic [N_OUT-1:0] out_y
);

    localparam int W = N_IN + N_OUT;
    localparam logic [RW:0] N_OUT_W = (RW + 1)'(N_OUT);

    state_e                 state_q, state_d;
    logic [N_IN:0]          cnt_q, cnt_d;
    logic [N_OUT-1:0][N_IN-1:0] mat_q, mat_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   cfg_ok;
    logic                   push_vld;
    logic [N_IN-1:0]        push_x;
    logic [N_OUT-1:0]       push_y;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [W-1:0]           head_dat;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        push_vld   = 1'b0;
        push_x     = in_x;
        in_ready   = 1'b0;
        sweep_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = !fifo_full;
                push_vld = in_valid && !fifo_full;
                if (sweep_start) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                push_x = cnt_q[N_IN-1:0];
                if (!fifo_full) begin
                    push_vld = 1'b1;
                    cnt_d    = cnt_q + {{N_IN{1'b0}}, 1'b1};
                    if (cnt_q[N_IN-1:0] == '1) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    sweep_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The push uses the current matrix, so a same-cycle write only affects later pushes.
    assign push_y = xform(push_x, mat_q);

    assign cfg_ok    = (state_q == IDLE) && ({1'b0, cfg_row} < N_OUT_W);
    assign cfg_err_d = cfg_we && !cfg_ok;

    always_comb begin
        mat_d = mat_q;
        if (cfg_we && cfg_ok) mat_d[cfg_row] = cfg_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
            for (int k = 0; k < N_OUT; k++) begin
                mat_q[k] <= identity_row(k);
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_err_d;
            mat_q     <= mat_d;
        end
    end

    assign cfg_err    = cfg_err_q;
    assign sweep_busy = (state_q != IDLE);

    autosym_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_vld_i (push_vld),
        .push_dat_i ({push_x, push_y}),
        .pop_i      (out_ready),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_dat_o (head_dat)
    );

    assign out_valid = !fifo_empty;
    assign out_x     = head_dat[W-1:N_OUT];
    assign out_y     = head_dat[N_OUT-1:0];

endmodule

// File: tb/tb_autosym_xform_stage.sv
// Directed bench for autosym_xform_stage with a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_autosym_xform_stage;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [5:0] in_x;
    logic       cfg_we;
    logic [2:0] cfg_row;
    logic [5:0] cfg_data;
    logic       cfg_err;
    logic       sweep_start, sweep_busy, sweep_done;
    logic       out_valid, out_ready;
    logic [5:0] out_x, out_y;

    always #5 clk = ~clk;

    autosym_xform_stage #(.N_IN(6), .N_OUT(6), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .cfg_we      (cfg_we),
        .cfg_row     (cfg_row),
        .cfg_data    (cfg_data),
        .cfg_err     (cfg_err),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_x       (out_x),
        .out_y       (out_y)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: queue of expected {x,y} pairs, the matrix as six row masks,
    // and the sweep phase as 0 = idle, 1 = generating, 2 = waiting for the queue to empty.
    logic [11:0] mq[$];
    logic [5:0]  mm[6];
    int          mode       = 0;
    int          sweep_next = 0;
    bit          err_pend   = 1'b0;

    function automatic logic [5:0] ref_y(input logic [5:0] x);
        logic [5:0] r;
        for (int k = 0; k < 6; k++) r[k] = (($countones(x & mm[k]) % 2) == 1);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            for (int k = 0; k < 6; k++) mm[k] = 6'(1 << k);
            mode       = 0;
            sweep_next = 0;
            err_pend   = 1'b0;
        end else begin
            int          sz;
            bit          do_pop, do_push, ok;
            logic [5:0]  px;
            logic [11:0] ent;
            sz      = mq.size();
            do_pop  = (sz > 0) && out_ready;
            do_push = 1'b0;
            px      = in_x;
            if (mode == 0 && in_valid && sz < DEPTH) do_push = 1'b1;
            if (mode == 1 && sz < DEPTH) begin
                do_push = 1'b1;
                px      = sweep_next[5:0];
            end
            ent      = {px, ref_y(px)};
            ok       = (mode == 0) && (cfg_row < 3'd6);
            err_pend = cfg_we && !ok;
            if (cfg_we && ok) mm[cfg_row] = cfg_data;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(ent);
            case (mode)
                0: if (sweep_start) begin mode = 1; sweep_next = 0; end
                1: if (do_push) begin
                       if (sweep_next == 63) mode = 2;
                       sweep_next++;
                   end
                default: if (sz == 0) mode = 0;
            endcase
        end
    end

    logic [11:0] pop_log[$];
    int          done_cnt = 0;

    // Per-cycle compare against the model, done mid-cycle; also records observed pops.
    task automatic compare_cycle();
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0 && out_valid) begin
            chk("out_x", 32'(out_x), 32'(mq[0][11:6]));
            chk("out_y", 32'(out_y), 32'(mq[0][5:0]));
        end
        chk("in_ready",   32'(in_ready),   32'(mode == 0 && mq.size() < DEPTH));
        chk("sweep_busy", 32'(sweep_busy), 32'(mode != 0));
        chk("sweep_done", 32'(sweep_done), 32'(mode == 2 && mq.size() == 0));
        chk("cfg_err",    32'(cfg_err),    32'(err_pend));
        if (out_valid && out_ready) pop_log.push_back({out_x, out_y});
        if (sweep_done) done_cnt++;
    endtask

    task automatic step();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] row, input logic [5:0] data);
        cfg_we = 1'b1; cfg_row = row; cfg_data = data;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        int bad, done0;
        rst_n = 1'b0; in_valid = 1'b0; in_x = '0; cfg_we = 1'b0; cfg_row = '0;
        cfg_data = '0; sweep_start = 1'b0; out_ready = 1'b0;
        repeat (2) step();
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_x",     32'(out_x),     32'd0);
        chk("rst_out_y",     32'(out_y),     32'd0);
        chk("rst_busy_done_err", 32'({sweep_busy, sweep_done, cfg_err}), 32'd0);
        rst_n = 1'b1;
        step();

        // Identity matrix pass-through.
        out_ready = 1'b1; in_valid = 1'b1; in_x = 6'b101101;
        step();
        in_valid = 1'b0;
        chk("id_valid", 32'(out_valid), 32'd1);
        chk("id_x", 32'(out_x), 32'h2d);
        chk("id_y", 32'(out_y), 32'h2d);
        step();

        // Programmed rows.
        cfg_write(3'd0, 6'b001010);
        cfg_write(3'd1, 6'b000101);
        in_valid = 1'b1; in_x = 6'b000110;
        step();
        in_valid = 1'b0;
        chk("prog_y", 32'(out_y), 32'b000111);
        step();

        // Write in the same cycle as a push: push sees the old row 2.
        in_valid = 1'b1; in_x = 6'b000100;
        cfg_we = 1'b1; cfg_row = 3'd2; cfg_data = 6'b000000;
        step();
        cfg_we = 1'b0;
        chk("same_cycle_old_y", 32'(out_y), 32'b000110);
        step();
        in_valid = 1'b0;
        chk("next_cycle_new_y", 32'(out_y), 32'b000010);
        step();
        for (int k = 0; k < 3; k++) cfg_write(3'(k), 6'(1 << k));

        // Out-of-range row in IDLE is dropped.
        cfg_write(3'd6, 6'b111111);
        chk("bad_row_err", 32'(cfg_err), 32'd1);
        step();
        chk("bad_row_err_clr", 32'(cfg_err), 32'd0);

        // Backpressure: four accepted, fifth waits, drain in order.
        out_ready = 1'b0;
        pop_log.delete();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_x = 6'(i);
            step();
        end
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        in_x = 6'd4;
        step();
        chk("bp_head_stable", 32'(out_x), 32'd0);
        chk("bp_still_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        repeat (6) step();
        chk("bp_pop_count", 32'(pop_log.size()), 32'd5);
        bad = 0;
        for (int i = 0; i < pop_log.size(); i++) if (pop_log[i][11:6] != 6'(i)) bad++;
        chk("bp_order_errs", 32'(bad), 32'd0);

        // Full sweep with a rejected config write and an ignored restart.
        pop_log.delete();
        done0 = done_cnt;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        chk("sweep_busy_on", 32'(sweep_busy), 32'd1);
        cfg_write(3'd0, 6'b000000);
        chk("busy_cfg_err", 32'(cfg_err), 32'd1);
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        chk("busy_cfg_err_clr", 32'(cfg_err), 32'd0);
        for (int i = 0; i < 300 && sweep_busy; i++) step();
        chk("sweep_timeout", 32'(sweep_busy), 32'd0);
        chk("sweep_pops", 32'(pop_log.size()), 32'd64);
        bad = 0;
        for (int i = 0; i < pop_log.size(); i++)
            if (pop_log[i] != {6'(i), 6'(i)}) bad++;
        chk("sweep_order_errs", 32'(bad), 32'd0);
        chk("sweep_done_once", 32'(done_cnt - done0), 32'd1);
        chk("sweep_in_ready", 32'(in_ready), 32'd1);
        step();

        // Reset partway through a sweep.
        cfg_write(3'd0, 6'b111111);
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        for (int i = 0; i < 200 && sweep_next != 20; i++) step();
        chk("reach_cnt20", 32'(sweep_next), 32'd20);
        done0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(sweep_busy), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        in_valid = 1'b1; in_x = 6'b000011;
        step();
        in_valid = 1'b0;
        chk("midrst_identity_y", 32'(out_y), 32'b000011);
        repeat (3) step();
        chk("midrst_no_done", 32'(done_cnt - done0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
